fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Issue/retire sequencer that sits directly upstream of the multi-cycle FP divider and also collects its output. It accepts single-precision operand pairs over a valid/ready handshake and drives the divider's run/x/y. It detects completion from the divider's stall, captures z into a small result FIFO, and returns it with classification flags over a second valid/ready handshake. This decouples the core's FP pipeline from the divider's fixed 27-cycle run protocol.

Parameters:
DEPTH, 2, result FIFO entries (power of 2, >=2)
TIMEOUT, 32, max cycles with div_run high before forced completion

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair offered
in_ready  out  1  sequencer accepts operands this cycle
in_x  in  32  dividend (IEEE single)
in_y  in  32  divisor (IEEE single)
div_run  out  1  divider run
div_x  out  32  divider x operand (held stable while div_run)
div_y  out  32  divider y operand (held stable while div_run)
div_stall  in  1  divider stall
div_z  in  32  divider result
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_z  out  32  quotient at FIFO head
out_flags  out  5  {tmo, unf, ovf, dz, zx} at FIFO head
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst high at a clk edge): state IDLE; div_run=0; div_x=div_y=0; FIFO emptied (out_valid=0, out_z=0, out_flags=0); cycle counter=0. Reset mid-RUN abandons the operation: no result is pushed, and div_run is low from the next cycle.
- State machine, 3 states:
  - IDLE: in_ready = (fifo_count < DEPTH). On in_valid & in_ready, latch in_x/in_y into div_x/div_y, set div_run=1, clear counter, go to RUN.
  - RUN: div_run=1; counter increments each cycle. When div_stall=0 (completion), push {div_z, flags, tmo=0}, set div_run=0, go to GAP. If counter reaches TIMEOUT-1 with div_stall still 1, push {div_z, flags, tmo=1}, set div_run=0, go to GAP.
  - GAP: div_run=0 for exactly one cycle, so the divider's step counter returns to 0. Then go to IDLE.
- in_ready=0 in RUN and GAP. Minimum issue interval is 29 cycles (27 RUN + 1 GAP + 1 IDLE).
- Latency: operands accepted at edge k, so div_run is high from k. The divider deasserts stall in its 27th run cycle. The result is pushed at edge k+27 and out_valid is high after edge k+27 (FIFO was empty).
- Push is always legal: issue only occurs with fifo_count < DEPTH, and count cannot grow during RUN.
- Flags are computed from the latched div_x/div_y and div_z; xe and ye are the exponent fields, bits 30:23.
  - zx = (xe==0)
  - dz = (xe!=0 & ye==0)
  - ovf = (xe!=0 & ye!=0 & div_z[30:23]==8'hFF)
  - unf = (xe!=0 & ye!=0 & div_z[30:0]==0)
  - tmo as set by the state machine.
- FIFO: head drives out_z/out_flags; pop on out_valid & out_ready. Simultaneous push and pop in the same cycle is allowed and count is unchanged. Pop from empty is ignored. Read/write pointers wrap modulo DEPTH. out_z/out_flags hold stable while out_valid & ~out_ready.
- in_x/in_y are ignored when not accepted; div_x/div_y change only on accept or reset.

Test Plan:
- Single op: x=0x3F800000, y=0x40000000, out_ready=1 -> div_run high 27 cycles, then low 1 cycle; out_valid at cycle 27 after accept with out_z=0x3F000000 and out_flags=0.
- Div by zero: x=0x3F800000, y=0x00000000 -> out_z=0x7F800000, out_flags=5'b00010. Zero dividend: x=0, y=0x40000000 -> out_z=0, out_flags=5'b00001.
- Backpressure: out_ready=0, issue 3 ops -> first 2 complete; in_ready stays 0 after the 2nd result is pushed. A pop then raises in_ready, and the 3rd op is accepted the next IDLE cycle. FIFO order is preserved.
- Back-to-back: in_valid held high with out_ready=1 -> div_run low exactly 1 cycle between ops; accepts spaced 29 cycles apart.
- Timeout: stub divider holds div_stall=1 -> push at counter=TIMEOUT-1 (32 cycles) with tmo=1; div_run drops; sequencer recovers to IDLE.
- Reset at RUN cycle 10 -> next cycle div_run=0, in_ready=1, out_valid=0; no stale result ever appears; the next op completes normally.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Handshake and divider-side signals of the FP divide sequencer.
// slave = sequencer side; master = environment (core, divider, consumer).
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        div_run;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_stall;
    logic [31:0] div_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_flags;
    logic        busy;

    modport slave (
        input  in_valid, in_x, in_y, div_stall, div_z, out_ready,
        output in_ready, div_run, div_x, div_y, out_valid, out_z, out_flags, busy
    );

    modport master (
        output in_valid, in_x, in_y, div_stall, div_z, out_ready,
        input  in_ready, div_run, div_x, div_y, out_valid, out_z, out_flags, busy
    );
endinterface

// File: rtl/fp_div_seq.sv
// Issue/retire sequencer for the multi-cycle FP divider: issues operand pairs,
// watches stall for completion (or times out), and queues classified results.
module fp_div_seq #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    fp_div_seq_if.slave io
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
    typedef struct packed {
        logic [31:0] z;
        logic [4:0]  flags;
    } res_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [31:0]   dx_q, dx_d, dy_q, dy_d;
    res_t          mem_q [DEPTH];
    res_t          mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   fcnt_q, fcnt_d;

    logic          in_rdy, push, pop, tmo;
    logic [7:0]    xe, ye;
    logic [4:0]    flags;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        push    = 1'b0;
        tmo     = 1'b0;
        in_rdy  = (state_q == IDLE) && (fcnt_q < (AW+1)'(DEPTH));

        case (state_q)
            IDLE: begin
                if (io.in_valid && in_rdy) begin
                    dx_d    = io.in_x;
                    dy_d    = io.in_y;
                    run_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Completion wins over timeout when both land on the same edge.
                if (!io.div_stall) begin
                    push    = 1'b1;
                    run_d   = 1'b0;
                    state_d = GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    push    = 1'b1;
                    tmo     = 1'b1;
                    run_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        xe    = dx_q[30:23];
        ye    = dy_q[30:23];
        flags = {tmo,
                 (xe != 8'h0) && (ye != 8'h0) && (io.div_z[30:0] == 31'h0),
                 (xe != 8'h0) && (ye != 8'h0) && (io.div_z[30:23] == 8'hFF),
                 (xe != 8'h0) && (ye == 8'h0),
                 (xe == 8'h0)};

        // Issue only happens with a free slot and count cannot grow in RUN,
        // so a push never finds the FIFO full.
        pop    = (fcnt_q != '0) && io.out_ready;
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (push) begin
            mem_d[wp_q] = '{z: io.div_z, flags: flags};
            wp_d        = wp_q + AW'(1);
        end
        if (pop) rp_d = rp_q + AW'(1);
        fcnt_d = fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fcnt_q  <= fcnt_d;
            mem_q   <= mem_d;
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.div_run   = run_q;
    assign io.div_x     = dx_q;
    assign io.div_y     = dy_q;
    assign io.out_valid = (fcnt_q != '0);
    assign io.out_z     = mem_q[rp_q].z;
    assign io.out_flags = mem_q[rp_q].flags;
    assign io.busy      = (state_q != IDLE) || (fcnt_q != '0);
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: stub divider with scripted answers, scoreboard of
// expected results from the classification rules, table and random phases.
module tb_fp_div_seq;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_div_seq_if io ();
    fp_div_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_flags(input logic [31:0] x, y, z, input bit hang);
        bit xz = (x[30:23] == 0);
        bit yz = (y[30:23] == 0);
        bit both = !xz && !yz;
        return {hang, both && (z[30:0] == 0), both && (z[30:23] == 8'hFF), !xz && yz, xz};
    endfunction

    typedef struct { logic [31:0] z; bit hang; } ans_t;
    typedef struct { logic [31:0] z; logic [4:0] fl; } exp_t;
    ans_t ans_q[$];
    exp_t exp_q[$];

    // Stub divider: finishes in its 27th run cycle unless told to hang.
    int          run_cnt  = 0;
    logic [31:0] stub_z   = '0;
    bit          cur_hang = 1'b0;
    assign io.div_stall = io.div_run && (cur_hang || run_cnt < LAT - 1);
    assign io.div_z     = stub_z;
    always @(posedge clk) begin
        run_cnt <= io.div_run ? run_cnt + 1 : 0;
        if (io.div_run && run_cnt == 0) begin
            if (ans_q.size() > 0) begin
                stub_z   <= ans_q[0].z;
                cur_hang <= ans_q[0].hang;
                void'(ans_q.pop_front());
            end else begin
                stub_z   <= '0;
                cur_hang <= 1'b0;
            end
        end
    end

    bit rnd_rdy   = 1'b0;
    bit fixed_rdy = 1'b1;
    always @(posedge clk) begin
        #1;
        io.out_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : fixed_rdy;
    end

    // Scoreboard and output-stability monitor.
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pz = '0;
    logic [4:0]  pf = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && io.out_valid) begin
                chk("hold_z", 64'(io.out_z), 64'(pz));
                chk("hold_flags", 64'(io.out_flags), 64'(pf));
            end
            if (io.in_ready) chk("ready_while_running", 64'(io.div_run), 64'(0));
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
                else begin
                    chk("sb_z", 64'(io.out_z), 64'(exp_q[0].z));
                    chk("sb_flags", 64'(io.out_flags), 64'(exp_q[0].fl));
                    void'(exp_q.pop_front());
                end
            end
        end
        pv <= io.out_valid;
        pr <= io.out_ready;
        pz <= io.out_z;
        pf <= io.out_flags;
    end

    task automatic expect_op(input logic [31:0] x, y, z, input bit hang);
        ans_t a;
        exp_t e;
        a.z = z; a.hang = hang;
        e.z = z; e.fl = ref_flags(x, y, z, hang);
        ans_q.push_back(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_acc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (io.in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.in_x = $urandom;
        io.in_y = $urandom;
    endtask

    task automatic issue(input logic [31:0] x, y, z, input bit hang);
        bit ok;
        expect_op(x, y, z, hang);
        @(posedge clk); #1;
        io.in_x = x; io.in_y = y; io.in_valid = 1'b1;
        wait_acc(ok);
        chk("accept", 64'(ok), 64'(1));
        chk("div_x_latch", 64'(io.div_x), 64'(x));
        chk("div_y_latch", 64'(io.div_y), 64'(y));
    endtask

    task automatic measure(output int lat, output int runs);
        bit done = 1'b0;
        lat = -1; runs = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            @(negedge clk);
            if (io.div_run) runs++;
            if (io.out_valid) begin lat = n - 1; done = 1'b1; end
        end
    endtask

    task automatic wait_idle(input string name, input int lim);
        bit done = 1'b0;
        for (int n = 0; n < lim && !done; n++) begin
            @(negedge clk);
            if (!io.busy && exp_q.size() == 0) done = 1'b1;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    function automatic logic [31:0] rand_fp(input bit is_z);
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 4))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: if (is_z) v[30:0] = '0;
            default: ;
        endcase
        return v;
    endfunction

    typedef struct { logic [31:0] x, y, z; logic [4:0] ef; } vec_t;
    vec_t vt[6];

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, runs, bad, na, runs1;
        int acc[3];
        bit ok;

        vt[0] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 5'b00000};
        vt[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b00010};
        vt[2] = '{32'h00000000, 32'h40000000, 32'h00000000, 5'b00001};
        vt[3] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 5'b00100};
        vt[4] = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b01000};
        vt[5] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b00001};

        io.in_valid = 1'b0; io.in_x = '0; io.in_y = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_div_run", 64'(io.div_run), 64'(0));
        chk("rst_div_x", 64'(io.div_x), 64'(0));
        chk("rst_div_y", 64'(io.div_y), 64'(0));
        chk("rst_out_valid", 64'(io.out_valid), 64'(0));
        chk("rst_out_z", 64'(io.out_z), 64'(0));
        chk("rst_out_flags", 64'(io.out_flags), 64'(0));
        chk("rst_in_ready", 64'(io.in_ready), 64'(1));
        chk("rst_busy", 64'(io.busy), 64'(0));

        // Single-op table: latency, run length, GAP, result and flags.
        foreach (vt[i]) begin
            issue(vt[i].x, vt[i].y, vt[i].z, 1'b0);
            measure(lat, runs);
            chk("tbl_latency", 64'(lat), 64'(LAT));
            chk("tbl_run_cycles", 64'(runs), 64'(LAT));
            chk("tbl_out_z", 64'(io.out_z), 64'(vt[i].z));
            chk("tbl_out_flags", 64'(io.out_flags), 64'(vt[i].ef));
            chk("tbl_gap_ready", 64'(io.in_ready), 64'(0));
            @(negedge clk);
            chk("tbl_idle_ready", 64'(io.in_ready), 64'(1));
            chk("tbl_idle_run", 64'(io.div_run), 64'(0));
        end
        wait_idle("drain_table", 50);

        // Backpressure: two results fill the FIFO, third op must wait for a pop.
        fixed_rdy = 1'b0;
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0);
        issue(32'h40800000, 32'h40000000, 32'h40000000, 1'b0);
        expect_op(32'h40A00000, 32'h40000000, 32'h40200000, 1'b0);
        @(posedge clk); #1;
        io.in_x = 32'h40A00000; io.in_y = 32'h40000000; io.in_valid = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.in_ready) bad++;
        end
        chk("bp_in_ready_held", 64'(bad), 64'(0));
        chk("bp_out_valid", 64'(io.out_valid), 64'(1));
        chk("bp_busy", 64'(io.busy), 64'(1));
        chk("bp_no_run", 64'(io.div_run), 64'(0));
        fixed_rdy = 1'b1;
        wait_acc(ok);
        chk("bp_third_accept", 64'(ok), 64'(1));
        chk("bp_third_div_x", 64'(io.div_x), 64'(32'h40A00000));
        wait_idle("drain_bp", 100);

        // Back-to-back issue with in_valid held.
        for (int i = 0; i < 3; i++) expect_op(32'h3F800000, 32'h40000000, 32'h3F000000 + i, 1'b0);
        @(posedge clk); #1;
        io.in_x = 32'h3F800000; io.in_y = 32'h40000000; io.in_valid = 1'b1;
        na = 0; runs1 = 0;
        for (int n = 0; n < 200 && na < 3; n++) begin
            @(negedge clk);
            if (na == 1 && io.div_run) runs1++;
            if (io.in_valid && io.in_ready) begin acc[na] = cyc; na++; end
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        chk("b2b_accepts", 64'(na), 64'(3));
        chk("b2b_interval1", 64'(acc[1] - acc[0]), 64'(29));
        chk("b2b_interval2", 64'(acc[2] - acc[1]), 64'(29));
        chk("b2b_run_cycles", 64'(runs1), 64'(LAT));
        wait_idle("drain_b2b", 100);

        // Timeout with a hung divider, then a normal op.
        issue(32'h3F800000, 32'h40000000, 32'h12345678, 1'b1);
        measure(lat, runs);
        chk("tmo_run_cycles", 64'(runs), 64'(TIMEOUT));
        chk("tmo_latency", 64'(lat), 64'(TIMEOUT));
        chk("tmo_flag", 64'(io.out_flags[4]), 64'(1));
        chk("tmo_run_low", 64'(io.div_run), 64'(0));
        issue(32'h40000000, 32'h3F800000, 32'h40000000, 1'b0);
        measure(lat, runs);
        chk("tmo_recover_latency", 64'(lat), 64'(LAT));
        wait_idle("drain_tmo", 50);

        // Reset sampled at the end of RUN cycle 10.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        ans_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_run_div_run", 64'(io.div_run), 64'(0));
        chk("rst_run_in_ready", 64'(io.in_ready), 64'(1));
        chk("rst_run_out_valid", 64'(io.out_valid), 64'(0));
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.out_valid) bad++;
        end
        chk("rst_no_stale", 64'(bad), 64'(0));
        issue(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0);
        measure(lat, runs);
        chk("rst_next_latency", 64'(lat), 64'(LAT));
        wait_idle("drain_rst", 50);

        // Random operands, answers, hangs and consumer stalls.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++)
            issue(rand_fp(1'b0), rand_fp(1'b0), rand_fp(1'b1), $urandom_range(0, 9) == 0);
        wait_idle("drain_random", 3000);
        chk("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
